ysyx_bht: RTL

- Branch history/target table feeding the IF stage with taken/target predictions.
- Trained from EX by the resolved branch outcome (BrE) and the 3-bit branch type.
- Sits between the PC-select logic (consumer of prediction) and the EX branch comparator (producer of resolution).
- Direct-mapped, tagged entries; each holds a 2-bit saturating counter and a 32-bit target.

---
 rtl/ysyx_bpu_pkg.sv | 30 +++
 rtl/ysyx_sat_ctr2.sv | 23 ++
 rtl/ysyx_bht.sv | 139 +++++++++++++
 3 files changed

// File: rtl/ysyx_bpu_pkg.sv
// rtl/ysyx_bpu_pkg.sv - shared branch-type, counter and table-entry definitions for the BHT
package ysyx_bpu_pkg;

    localparam logic [2:0] BR_BEQ  = 3'b010;
    localparam logic [2:0] BR_BNE  = 3'b011;
    localparam logic [2:0] BR_BLT  = 3'b100;
    localparam logic [2:0] BR_BGE  = 3'b101;
    localparam logic [2:0] BR_BLTU = 3'b110;
    localparam logic [2:0] BR_BGEU = 3'b111;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    // Widest tag any legal IDX_W/TAG_W split can produce; narrower tags are zero-extended.
    localparam int TAG_MAX_W = 30;

    typedef struct packed {
        logic                 valid;
        logic [TAG_MAX_W-1:0] tag;
        logic [1:0]           ctr;
        logic [31:0]          target;
    } bht_entry_t;

    function automatic logic is_branch_type(input logic [2:0] br_type);
        return br_type[2:1] != 2'b00;
    endfunction

endpackage

// File: rtl/ysyx_sat_ctr2.sv
// rtl/ysyx_sat_ctr2.sv - 2-bit saturating counter next-state function
module ysyx_sat_ctr2
    import ysyx_bpu_pkg::*;
(
    input  logic [1:0] i_ctr,
    input  logic       i_taken,
    output logic [1:0] o_ctr
);

    always_comb begin
        o_ctr = i_ctr;
        if (i_taken) begin
            if (i_ctr != CTR_ST) begin
                o_ctr = i_ctr + 2'd1;
            end
        end else begin
            if (i_ctr != CTR_SNT) begin
                o_ctr = i_ctr - 2'd1;
            end
        end
    end

endmodule

// File: rtl/ysyx_bht.sv
// rtl/ysyx_bht.sv - direct-mapped tagged branch history/target table; YSYX_BHT_BYPASS_EN forwards same-cycle updates
module ysyx_bht
    import ysyx_bpu_pkg::*;
#(
    parameter int IDX_W = 6,
    parameter int TAG_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_valid,
    input  logic [31:0] if_pc,
    output logic        pred_valid,
    output logic        pred_hit,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic [2:0]  upd_type,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_pred_taken,
    output logic [31:0] mispredict_cnt
);

    localparam int ENTRIES = 1 << IDX_W;

    bht_entry_t r_table [ENTRIES];

    logic        r_pred_valid;
    logic        r_pred_hit;
    logic        r_pred_taken;
    logic [31:0] r_pred_target;
    logic [31:0] r_mispredict_cnt;

    logic [IDX_W-1:0]     w_lk_idx;
    logic [TAG_MAX_W-1:0] w_lk_tag;
    logic [IDX_W-1:0]     w_upd_idx;
    logic [TAG_MAX_W-1:0] w_upd_tag;

    assign w_lk_idx  = if_pc[IDX_W+1:2];
    assign w_lk_tag  = TAG_MAX_W'(if_pc[IDX_W+TAG_W+1:IDX_W+2]);
    assign w_upd_idx = upd_pc[IDX_W+1:2];
    assign w_upd_tag = TAG_MAX_W'(upd_pc[IDX_W+TAG_W+1:IDX_W+2]);

    // Bits outside the index/tag window never affect the table.
    logic w_unused_upd_pc;
    assign w_unused_upd_pc = ^upd_pc;

    bht_entry_t w_upd_old;
    bht_entry_t w_upd_new;
    bht_entry_t w_upd_post;
    logic       w_upd_legal;
    logic       w_upd_hit;
    logic       w_upd_write;
    logic [1:0] w_ctr_next;

    assign w_upd_old   = r_table[w_upd_idx];
    assign w_upd_legal = upd_valid && is_branch_type(upd_type);
    assign w_upd_hit   = w_upd_old.valid && (w_upd_old.tag == w_upd_tag);
    assign w_upd_write = w_upd_legal && (w_upd_hit || upd_taken);

    ysyx_sat_ctr2 u_sat_ctr (
        .i_ctr   (w_upd_old.ctr),
        .i_taken (upd_taken),
        .o_ctr   (w_ctr_next)
    );

    always_comb begin
        w_upd_new = w_upd_old;
        if (w_upd_hit) begin
            w_upd_new.ctr = w_ctr_next;
            if (upd_taken) begin
                w_upd_new.target = upd_target;
            end
        end else begin
            w_upd_new.valid  = 1'b1;
            w_upd_new.tag    = w_upd_tag;
            w_upd_new.ctr    = CTR_WT;
            w_upd_new.target = upd_target;
        end
    end

    assign w_upd_post = w_upd_write ? w_upd_new : w_upd_old;

    bht_entry_t  w_lk_ent;
    logic        w_lk_hit;
    logic        w_lk_taken;
    logic [31:0] w_lk_target;

`ifdef YSYX_BHT_BYPASS_EN
    logic w_fwd;
    assign w_fwd    = w_upd_legal && (w_upd_idx == w_lk_idx) && (w_upd_tag == w_lk_tag);
    assign w_lk_ent = w_fwd ? w_upd_post : r_table[w_lk_idx];
`else
    logic w_unused_post;
    assign w_unused_post = ^w_upd_post;
    assign w_lk_ent      = r_table[w_lk_idx];
`endif

    assign w_lk_hit    = w_lk_ent.valid && (w_lk_ent.tag == w_lk_tag);
    assign w_lk_taken  = w_lk_hit && w_lk_ent.ctr[1];
    assign w_lk_target = w_lk_taken ? w_lk_ent.target : (if_pc + 32'd4);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_table[i] <= '{valid: 1'b0, tag: '0, ctr: CTR_WNT, target: 32'd0};
            end
            r_pred_valid     <= 1'b0;
            r_pred_hit       <= 1'b0;
            r_pred_taken     <= 1'b0;
            r_pred_target    <= 32'd0;
            r_mispredict_cnt <= 32'd0;
        end else begin
            if (w_upd_write) begin
                r_table[w_upd_idx] <= w_upd_new;
            end
            r_pred_valid <= if_valid;
            if (if_valid) begin
                r_pred_hit    <= w_lk_hit;
                r_pred_taken  <= w_lk_taken;
                r_pred_target <= w_lk_target;
            end else begin
                r_pred_hit   <= 1'b0;
                r_pred_taken <= 1'b0;
            end
            if (w_upd_legal && (upd_pred_taken != upd_taken)) begin
                r_mispredict_cnt <= r_mispredict_cnt + 32'd1;
            end
        end
    end

    assign pred_valid     = r_pred_valid;
    assign pred_hit       = r_pred_hit;
    assign pred_taken     = r_pred_taken;
    assign pred_target    = r_pred_target;
    assign mispredict_cnt = r_mispredict_cnt;

endmodule
